sine_cos_gen: RTL



---
 rtl/sine_cos_pkg.sv | 14 +
 rtl/sine_cos_gen_if.sv | 30 +++
 rtl/sine_cos_gen_minsky_step.sv | 15 +
 rtl/sine_cos_gen.sv | 102 ++++++++++
 4 files changed

// File: rtl/sine_cos_pkg.sv
// rtl/sine_cos_pkg.sv - shared FSM states and shift-clamp bounds for sine_cos_gen
package sine_cos_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int unsigned K_MIN = 1;

  // Largest usable shift for a W-bit state; beyond this the update term vanishes.
  function automatic int unsigned k_max(input int unsigned w);
    return w - 2;
  endfunction

endpackage

// File: rtl/sine_cos_gen_if.sv
// rtl/sine_cos_gen_if.sv - control and sample-stream bundle for sine_cos_gen
interface sine_cos_gen_if #(
  parameter int W     = 16,
  parameter int SH_W  = 4,
  parameter int CNT_W = 16
);
  logic                    start;
  logic                    stop;
  logic                    mode;
  logic signed [W-1:0]     amp;
  logic [SH_W-1:0]         shift;
  logic [CNT_W-1:0]        burst_len;
  logic                    out_ready;
  logic                    out_valid;
  logic signed [W-1:0]     sine;
  logic signed [W-1:0]     cos;
  logic                    busy;
  logic                    done;
  logic [CNT_W-1:0]        period;

  modport master (
    input  start, stop, mode, amp, shift, burst_len, out_ready,
    output out_valid, sine, cos, busy, done, period
  );

  modport slave (
    output start, stop, mode, amp, shift, burst_len, out_ready,
    input  out_valid, sine, cos, busy, done, period
  );
endinterface

// File: rtl/sine_cos_gen_minsky_step.sv
// rtl/sine_cos_gen_minsky_step.sv - one combinational Minsky circle update
module minsky_step #(
  parameter int W    = 16,
  parameter int SH_W = 4
) (
  input  logic signed [W-1:0] sine,
  input  logic signed [W-1:0] cos,
  input  logic [SH_W-1:0]     k,
  output logic signed [W-1:0] s_n,
  output logic signed [W-1:0] c_n
);
  // cos update uses the new sine; that ordering keeps the orbit closed.
  assign s_n = sine + (cos >>> k);
  assign c_n = cos - (s_n >>> k);
endmodule

// File: rtl/sine_cos_gen.sv
// rtl/sine_cos_gen.sv - stallable sine/cos oscillator; SINCOS_PERIOD_EN adds zero-crossing period measurement
module sine_cos_gen
  import sine_cos_pkg::*;
#(
  parameter int W     = 16,
  parameter int SH_W  = 4,
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            reset,
  sine_cos_gen_if.master bus
);
  logic [0:0]          state_r;
  logic signed [W-1:0] sine_r, cos_r, s_n, c_n;
  logic [SH_W-1:0]     k_r, k_clamped;
  logic                mode_r;
  logic [CNT_W-1:0]    len_r, count_r;
  logic                run, init, step, last;

  assign run  = (state_r == ST_RUN);
  assign init = bus.start & ~bus.stop;
  // stop and start both pre-empt a concurrent accept
  assign step = run & bus.out_ready & ~bus.stop & ~bus.start;
  // len_r of 0 wraps to all-ones, giving a 2^CNT_W burst
  assign last = mode_r & (count_r == (len_r - CNT_W'(1)));

  always_comb begin
    k_clamped = bus.shift;
    if (32'(bus.shift) < K_MIN)
      k_clamped = SH_W'(K_MIN);
    else if (32'(bus.shift) > k_max(W))
      k_clamped = SH_W'(k_max(W));
  end

  minsky_step #(.W(W), .SH_W(SH_W)) u_step (
    .sine (sine_r),
    .cos  (cos_r),
    .k    (k_r),
    .s_n  (s_n),
    .c_n  (c_n)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      sine_r  <= '0;
      cos_r   <= '0;
      k_r     <= SH_W'(K_MIN);
      mode_r  <= 1'b0;
      len_r   <= '0;
      count_r <= '0;
    end else if (run && bus.stop) begin
      state_r <= ST_IDLE;
    end else if (init) begin
      state_r <= ST_RUN;
      sine_r  <= '0;
      cos_r   <= bus.amp;
      k_r     <= k_clamped;
      mode_r  <= bus.mode;
      len_r   <= bus.burst_len;
      count_r <= '0;
    end else if (step) begin
      sine_r  <= s_n;
      cos_r   <= c_n;
      count_r <= count_r + CNT_W'(1);
      if (last)
        state_r <= ST_IDLE;
    end
  end

  assign bus.out_valid = run;
  assign bus.busy      = run;
  assign bus.sine      = sine_r;
  assign bus.cos       = cos_r;
  assign bus.done      = step & last;

`ifdef SINCOS_PERIOD_EN
  logic [CNT_W-1:0] per_cnt_r, period_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_cnt_r <= '0;
      period_r  <= '0;
    end else if (init) begin
      per_cnt_r <= '0;
    end else if (step) begin
      // positive-going zero crossing closes one period
      if (sine_r[W-1] && !s_n[W-1]) begin
        period_r  <= per_cnt_r + CNT_W'(1);
        per_cnt_r <= '0;
      end else begin
        per_cnt_r <= per_cnt_r + CNT_W'(1);
      end
    end
  end

  assign bus.period = period_r;
`else
  assign bus.period = '0;
`endif

endmodule
